ucie_ctl_sb_tx_arbiter: RTL and testbench



---
 rtl/ucie_ctl_sb_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ucie_ctl_sb_tx_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// ucie_ctl_sb_tx_arbiter
// Shares the sideband transmit channel toward the remote die between NREQ
// on-die message sources. Arbitration is round-robin with a per-message
// lock. New messages are only granted while remote receive credits remain.
// Optional macro SB_ARB_STRICT_PRIO_EN: when defined, the winner is the
// lowest-index valid source and no round-robin pointer is kept.

// Protocol invariants for the arbiter outputs, instantiated by the top.
module ucie_ctl_sb_tx_arbiter_chk #(
  parameter int NREQ    = 3,
  parameter int CRD_MAX = 4,
  parameter int CRD_W   = $clog2(CRD_MAX + 1)
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic [NREQ-1:0]  i_ready,
  input logic             i_sb_valid,
  input logic             i_sb_last,
  input logic [CRD_W-1:0] i_crd_count
);

  // At most one source may be accepted per cycle.
  a_ready_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(i_ready));

  // The credit counter never exceeds its reset value.
  a_crd_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_crd_count <= CRD_W'(CRD_MAX)));

  // A last flag is only meaningful on a valid beat.
  a_last_qualified : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_sb_last |-> i_sb_valid));

endmodule

module ucie_ctl_sb_tx_arbiter #(
  parameter int NC      = 32,
  parameter int NREQ    = 3,
  parameter int CRD_MAX = 4,
  parameter int CRD_W   = $clog2(CRD_MAX + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ-1:0]         i_req_last,
  input  logic [NREQ*NC-1:0]      i_req_data,
  output logic [NREQ-1:0]         o_req_ready,
  output logic                    o_sb_data_valid,
  output logic                    o_sb_last,
  output logic [NC-1:0]           o_data_sent_sb,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  output logic                    o_busy,
  input  logic                    i_sb_crd_return,
  output logic [CRD_W-1:0]        o_crd_count,
  output logic                    o_crd_err
);

  localparam int ID_W = $clog2(NREQ);
  localparam logic [ID_W-1:0]  ID_ZERO  = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);
  localparam logic [CRD_W-1:0] CRD_ZERO = {CRD_W{1'b0}};
  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CRD_MAX);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ID_W-1:0]   grant_r;
  logic [ID_W-1:0]   grant_nxt_s;
  logic [CRD_W-1:0]  crd_r;
  logic [CRD_W-1:0]  crd_nxt_s;
  logic              crd_err_r;
  logic              crd_err_nxt_s;
  logic              sb_valid_r;
  logic              sb_last_r;
  logic [NC-1:0]     sb_data_r;

  logic              win_found_s;
  logic [ID_W-1:0]   win_id_s;
  logic [NREQ-1:0]   ready_s;
  logic [ID_W-1:0]   xfer_id_s;
  logic              xfer_s;
  logic              xfer_last_s;
  logic [NC-1:0]     xfer_data_s;
  logic              consume_s;

  // Successor index with wrap-around at NREQ.
  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] res;
    if (id == ID_LAST) begin
      res = ID_ZERO;
    end else begin
      res = id + ID_ONE;
    end
    return res;
  endfunction

`ifdef SB_ARB_STRICT_PRIO_EN
  // Fixed priority: the lowest-index valid source wins.
  always_comb begin
    logic take;
    win_found_s = 1'b0;
    win_id_s    = ID_ZERO;
    take        = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      take        = i_req_valid[j] & ~win_found_s;
      win_id_s    = take ? ID_W'(j) : win_id_s;
      win_found_s = win_found_s | take;
    end
  end
`else
  logic [ID_W-1:0] rr_r;
  logic [ID_W-1:0] rr_nxt_s;

  // Round-robin: first valid source scanning upward from the pointer.
  always_comb begin
    logic take;
    int   idx;
    win_found_s = 1'b0;
    win_id_s    = ID_ZERO;
    take        = 1'b0;
    idx         = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx         = int'(rr_r) + i;
      idx         = (idx >= NREQ) ? (idx - NREQ) : idx;
      take        = i_req_valid[idx] & ~win_found_s;
      win_id_s    = take ? ID_W'(idx) : win_id_s;
      win_found_s = win_found_s | take;
    end
  end

  // The pointer moves past whichever source just finished a message.
  always_comb begin
    rr_nxt_s = rr_r;
    if (xfer_s && xfer_last_s) begin
      rr_nxt_s = id_inc(xfer_id_s);
    end else begin
      rr_nxt_s = rr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_r <= ID_ZERO;
    end else begin
      rr_r <= rr_nxt_s;
    end
  end
`endif

  // Ready selection and beat mux: the lock owner while LOCKED, otherwise
  // the arbitration winner, but only when a credit is available.
  always_comb begin
    ready_s   = {NREQ{1'b0}};
    xfer_id_s = grant_r;
    if (state_r == ST_LOCKED) begin
      ready_s[grant_r] = 1'b1;
      xfer_id_s        = grant_r;
    end else if (win_found_s && (crd_r != CRD_ZERO)) begin
      ready_s[win_id_s] = 1'b1;
      xfer_id_s         = win_id_s;
    end else begin
      ready_s   = {NREQ{1'b0}};
      xfer_id_s = grant_r;
    end
    xfer_s      = |(ready_s & i_req_valid);
    xfer_last_s = i_req_last[xfer_id_s];
    xfer_data_s = i_req_data[int'(xfer_id_s) * NC +: NC];
    consume_s   = xfer_s & (state_r == ST_IDLE);
  end

  // Message lock FSM: multi-beat messages hold the channel until last.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s && !xfer_last_s) begin
          state_nxt_s = ST_LOCKED;
          grant_nxt_s = win_id_s;
        end else begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = ID_ZERO;
        end
      end
      ST_LOCKED: begin
        if (xfer_s && xfer_last_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = ID_ZERO;
        end else begin
          state_nxt_s = ST_LOCKED;
          grant_nxt_s = grant_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = ID_ZERO;
      end
    endcase
  end

  // Credit bookkeeping: simultaneous consume and return cancel out; a
  // return at full count saturates and raises the sticky error.
  always_comb begin
    crd_nxt_s     = crd_r;
    crd_err_nxt_s = crd_err_r;
    case ({consume_s, i_sb_crd_return})
      2'b10: begin
        crd_nxt_s = crd_r - CRD_ONE;
      end
      2'b01: begin
        if (crd_r == CRD_FULL) begin
          crd_err_nxt_s = 1'b1;
        end else begin
          crd_nxt_s = crd_r + CRD_ONE;
        end
      end
      default: begin
        crd_nxt_s = crd_r;
      end
    endcase
  end

  // State, grant and credit registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      grant_r   <= ID_ZERO;
      crd_r     <= CRD_FULL;
      crd_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      grant_r   <= grant_nxt_s;
      crd_r     <= crd_nxt_s;
      crd_err_r <= crd_err_nxt_s;
    end
  end

  // Output beat register: one cycle after acceptance, zero otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sb_valid_r <= 1'b0;
      sb_last_r  <= 1'b0;
      sb_data_r  <= {NC{1'b0}};
    end else begin
      sb_valid_r <= xfer_s;
      sb_last_r  <= xfer_s & xfer_last_s;
      sb_data_r  <= xfer_s ? xfer_data_s : {NC{1'b0}};
    end
  end

  assign o_req_ready     = ready_s;
  assign o_sb_data_valid = sb_valid_r;
  assign o_sb_last       = sb_last_r;
  assign o_data_sent_sb  = sb_data_r;
  assign o_grant_id      = grant_r;
  assign o_busy          = (state_r == ST_LOCKED);
  assign o_crd_count     = crd_r;
  assign o_crd_err       = crd_err_r;

  ucie_ctl_sb_tx_arbiter_chk #(
    .NREQ    (NREQ),
    .CRD_MAX (CRD_MAX),
    .CRD_W   (CRD_W)
  ) u_chk (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ready     (ready_s),
    .i_sb_valid  (sb_valid_r),
    .i_sb_last   (sb_last_r),
    .i_crd_count (crd_r)
  );

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arbiter.sv
// Directed bench for ucie_ctl_sb_tx_arbiter. Each source is fed from a
// queue of beats/gaps; expected output beats go to a scoreboard queue when
// stimulus is loaded and are popped by a monitor on o_sb_data_valid.
module tb_ucie_ctl_sb_tx_arbiter;

  localparam int NC = 32;
  localparam int NREQ = 3;
  localparam int CRD_MAX = 4;
  localparam int CRD_W = $clog2(CRD_MAX + 1);
  localparam logic [33:0] GAP = 34'h2_0000_0000;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ-1:0]    i_req_last;
  logic [NREQ*NC-1:0] i_req_data;
  logic [NREQ-1:0]    o_req_ready;
  logic               o_sb_data_valid;
  logic               o_sb_last;
  logic [NC-1:0]      o_data_sent_sb;
  logic [1:0]         o_grant_id;
  logic               o_busy;
  logic               i_sb_crd_return;
  logic [CRD_W-1:0]   o_crd_count;
  logic               o_crd_err;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int out_cnt = 0;
  int lock_viol = 0;
  logic lock_watch = 1'b0;
  logic lock_done = 1'b0;
  logic auto_ret = 1'b0;
  logic [NREQ-1:0] in_msg = '0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [33:0] q2[$];
  logic [32:0] exp_q[$];

  ucie_ctl_sb_tx_arbiter #(.NC(NC), .NREQ(NREQ), .CRD_MAX(CRD_MAX)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (i_req_valid),
    .i_req_last      (i_req_last),
    .i_req_data      (i_req_data),
    .o_req_ready     (o_req_ready),
    .o_sb_data_valid (o_sb_data_valid),
    .o_sb_last       (o_sb_last),
    .o_data_sent_sb  (o_data_sent_sb),
    .o_grant_id      (o_grant_id),
    .o_busy          (o_busy),
    .i_sb_crd_return (i_sb_crd_return),
    .o_crd_count     (o_crd_count),
    .o_crd_err       (o_crd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [33:0] beat(input logic last, input logic [31:0] data);
    return {1'b0, last, data};
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [33:0] qfront(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic push_src(input int k, input logic [33:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic push_exp(input logic last, input logic [31:0] data);
    exp_q.push_back({last, data});
  endtask

  // Present each source's queue front on its request port.
  task automatic apply_drive();
    logic [33:0] f;
    for (int k = 0; k < NREQ; k++) begin
      if (qsize(k) == 0) begin
        i_req_valid[k] = 1'b0;
        i_req_last[k] = 1'b0;
        i_req_data[k*NC +: NC] = '0;
      end else begin
        f = qfront(k);
        i_req_valid[k] = ~f[33];
        i_req_last[k] = f[32] & ~f[33];
        i_req_data[k*NC +: NC] = f[33] ? 32'h0 : f[31:0];
      end
    end
  endtask

  // One clock: sample handshakes at the falling edge, advance sources after
  // the rising edge; optionally return one credit per first beat accepted.
  task automatic step(input logic ret);
    logic [NREQ-1:0] acc;
    logic [33:0] f;
    logic first_any;
    @(negedge clk);
    acc = i_req_valid & o_req_ready;
    if (lock_watch && !lock_done && o_req_ready[0]) lock_viol++;
    if (lock_watch && acc[1] && i_req_last[1]) lock_done = 1'b1;
    @(posedge clk);
    #1;
    first_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (qsize(k) != 0) begin
        f = qfront(k);
        if (f[33]) begin
          qpop(k);
        end else if (acc[k]) begin
          if (!in_msg[k]) first_any = 1'b1;
          in_msg[k] = ~f[32];
          qpop(k);
        end
      end
    end
    apply_drive();
    i_sb_crd_return = ret | (auto_ret & first_any);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size() + exp_q.size() != 0) && n < budget) begin
      step(1'b0);
      n++;
    end
    chk({tag, "_drained"}, 64'(q0.size() + q1.size() + q2.size() + exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every output beat must match the next expected one.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && o_sb_data_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'(o_data_sent_sb), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(o_data_sent_sb), 64'(e[31:0]));
        chk("sb_last", 64'(o_sb_last), 64'(e[32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int out_base;
    rst_n = 1'b0;
    i_req_valid = '0;
    i_req_last = '0;
    i_req_data = '0;
    i_sb_crd_return = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state with all sources idle.
    chk("rst_crd_count", 64'(o_crd_count), 64'd4);
    chk("rst_sb_valid", 64'(o_sb_data_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_grant_id", 64'(o_grant_id), 64'd0);
    chk("rst_crd_err", 64'(o_crd_err), 64'd0);
    chk("rst_ready", 64'(o_req_ready), 64'd0);

    // Round-robin, two identical rounds, credits returned as consumed.
    auto_ret = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_src(0, beat(1'b1, 32'hA0));
      push_src(1, beat(1'b1, 32'hB1));
      push_src(2, beat(1'b1, 32'hC2));
      push_exp(1'b1, 32'hA0);
      push_exp(1'b1, 32'hB1);
      push_exp(1'b1, 32'hC2);
      apply_drive();
      drain("rr_round", 40);
    end
    chk("rr_crd_restored", 64'(o_crd_count), 64'd4);

    // Source 0 re-requests while source 1 waits: fairness vs. priority.
    push_src(0, beat(1'b1, 32'h10));
    push_src(0, beat(1'b1, 32'h11));
    push_src(0, beat(1'b1, 32'h12));
    push_src(1, beat(1'b1, 32'h20));
`ifdef SB_ARB_STRICT_PRIO_EN
    push_exp(1'b1, 32'h10);
    push_exp(1'b1, 32'h11);
    push_exp(1'b1, 32'h12);
    push_exp(1'b1, 32'h20);
`else
    push_exp(1'b1, 32'h10);
    push_exp(1'b1, 32'h20);
    push_exp(1'b1, 32'h11);
    push_exp(1'b1, 32'h12);
`endif
    apply_drive();
    drain("rerequest", 40);

    // Lock: 3-beat message from source 1 with a 2-cycle gap, source 0 waiting.
    push_src(1, beat(1'b0, 32'h31));
    push_src(1, GAP);
    push_src(1, GAP);
    push_src(1, beat(1'b0, 32'h32));
    push_src(1, beat(1'b1, 32'h33));
    push_exp(1'b0, 32'h31);
    push_exp(1'b0, 32'h32);
    push_exp(1'b1, 32'h33);
    apply_drive();
    step(1'b0);
    chk("lock_busy", 64'(o_busy), 64'd1);
    chk("lock_grant_id", 64'(o_grant_id), 64'd1);
    push_src(0, beat(1'b1, 32'h40));
    push_exp(1'b1, 32'h40);
    apply_drive();
    lock_done = 1'b0;
    lock_watch = 1'b1;
    drain("lock", 40);
    lock_watch = 1'b0;
    chk("lock_ready0_held_low", 64'(lock_viol), 64'd0);
    chk("lock_released_idle", 64'(o_busy), 64'd0);
    chk("lock_crd_restored", 64'(o_crd_count), 64'd4);

    // Credit exhaustion: five messages, no returns.
    auto_ret = 1'b0;
    for (int m = 0; m < 5; m++) push_src(2, beat(1'b1, 32'h50 + 32'(m)));
    for (int m = 0; m < 4; m++) push_exp(1'b1, 32'h50 + 32'(m));
    out_base = out_cnt;
    apply_drive();
    repeat (6) step(1'b0);
    chk("exh_sent_count", 64'(out_cnt - out_base), 64'd4);
    chk("exh_crd_zero", 64'(o_crd_count), 64'd0);
    chk("exh_ready_stalled", 64'(o_req_ready), 64'd0);
    chk("exh_fifth_pending", 64'(q2.size()), 64'd1);
    push_exp(1'b1, 32'h54);
    step(1'b1);
    step(1'b0);
    chk("exh_crd_after_return", 64'(o_crd_count), 64'd1);
    chk("exh_ready_after_return", 64'(o_req_ready), 64'b100);
    step(1'b0);
    chk("exh_fifth_valid", 64'(o_sb_data_valid), 64'd1);
    chk("exh_fifth_data", 64'(o_data_sent_sb), 64'h54);
    chk("exh_crd_zero_again", 64'(o_crd_count), 64'd0);
    step(1'b0);
    chk("exh_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Simultaneous consume and return, then saturation at the maximum.
    i_sb_crd_return = 1'b1;
    step(1'b0);
    chk("sim_crd_one", 64'(o_crd_count), 64'd1);
    push_src(0, beat(1'b1, 32'h60));
    push_exp(1'b1, 32'h60);
    apply_drive();
    i_sb_crd_return = 1'b1;
    step(1'b0);
    chk("sim_consume_return", 64'(o_crd_count), 64'd1);
    chk("sim_no_err", 64'(o_crd_err), 64'd0);
    repeat (3) begin
      i_sb_crd_return = 1'b1;
      step(1'b0);
    end
    chk("sim_crd_full", 64'(o_crd_count), 64'd4);
    chk("sim_err_still_clear", 64'(o_crd_err), 64'd0);
    i_sb_crd_return = 1'b1;
    step(1'b0);
    chk("sim_crd_saturated", 64'(o_crd_count), 64'd4);
    chk("sim_err_set", 64'(o_crd_err), 64'd1);
    step(1'b0);
    chk("sim_err_sticky", 64'(o_crd_err), 64'd1);
    chk("sim_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Reset during beat 2 of a 3-beat message from source 1.
    push_src(1, beat(1'b0, 32'h71));
    push_src(1, beat(1'b0, 32'h72));
    push_src(1, beat(1'b1, 32'h73));
    apply_drive();
    step(1'b0);
    chk("mid_pre_valid", 64'(o_sb_data_valid), 64'd1);
    chk("mid_pre_busy", 64'(o_busy), 64'd1);
    chk("mid_pre_crd", 64'(o_crd_count), 64'd3);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    in_msg = '0;
    apply_drive();
    #1;
    chk("mid_rst_valid", 64'(o_sb_data_valid), 64'd0);
    chk("mid_rst_last", 64'(o_sb_last), 64'd0);
    chk("mid_rst_data", 64'(o_data_sent_sb), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_grant", 64'(o_grant_id), 64'd0);
    chk("mid_rst_crd", 64'(o_crd_count), 64'd4);
    chk("mid_rst_err", 64'(o_crd_err), 64'd0);
    chk("mid_rst_ready", 64'(o_req_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal traffic resumes after reset.
    auto_ret = 1'b1;
    push_src(0, beat(1'b1, 32'h80));
    push_src(2, beat(1'b1, 32'h82));
    push_exp(1'b1, 32'h80);
    push_exp(1'b1, 32'h82);
    apply_drive();
    drain("post_rst", 40);
    step(1'b0);
    chk("post_rst_crd", 64'(o_crd_count), 64'd4);
    chk("post_rst_idle", 64'(o_busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
